// File: rtl/prime_scan_ctrl.sv
// Sweep controller that steps a 4-bit prime detector through [lo, hi], streaming and counting primes.
// Optional result bitmap is built only when PRIME_SCAN_BITMAP_EN is defined.
module prime_scan_ctrl #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  lo,
  input  logic [3:0]  hi,
  output logic [3:0]  N,
  input  logic        F,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        prime_valid,
  output logic [3:0]  prime_value,
  output logic [4:0]  prime_count,
  output logic [15:0] bitmap
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic [3:0]  hi_q, hi_d;
  logic [3:0]  hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        prime_valid_q, prime_valid_d;
  logic [3:0]  prime_value_q, prime_value_d;
  logic [4:0]  prime_count_q, prime_count_d;
`ifdef PRIME_SCAN_BITMAP_EN
  logic [15:0] bitmap_q, bitmap_d;
`endif
  logic        sample;

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    hi_d          = hi_q;
    hold_d        = hold_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    prime_valid_d = 1'b0;
    prime_value_d = prime_value_q;
    prime_count_d = prime_count_q;
`ifdef PRIME_SCAN_BITMAP_EN
    bitmap_d      = bitmap_q;
`endif
    sample        = (state_q == SCAN) && (hold_q == HOLD_LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          prime_count_d = 5'd0;
`ifdef PRIME_SCAN_BITMAP_EN
          bitmap_d      = 16'h0000;
`endif
          n_d    = lo;
          hi_d   = hi;
          hold_d = 4'd0;
          if (lo <= hi) begin
            state_d = SCAN;
            busy_d  = 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      SCAN: begin
        if (sample) begin
          hold_d = 4'd0;
          if (F) begin
            prime_count_d = prime_count_q + 5'd1;
            prime_valid_d = 1'b1;
            prime_value_d = n_q;
`ifdef PRIME_SCAN_BITMAP_EN
            bitmap_d[n_q] = 1'b1;
`endif
          end
          // Compare against hi before incrementing so hi=15 never wraps to 0
          if (n_q == hi_q) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            n_d = n_q + 4'd1;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      n_q           <= 4'd0;
      hi_q          <= 4'd0;
      hold_q        <= 4'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      prime_valid_q <= 1'b0;
      prime_value_q <= 4'd0;
      prime_count_q <= 5'd0;
`ifdef PRIME_SCAN_BITMAP_EN
      bitmap_q      <= 16'h0000;
`endif
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      hi_q          <= hi_d;
      hold_q        <= hold_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      prime_valid_q <= prime_valid_d;
      prime_value_q <= prime_value_d;
      prime_count_q <= prime_count_d;
`ifdef PRIME_SCAN_BITMAP_EN
      bitmap_q      <= bitmap_d;
`endif
    end
  end

  assign N           = n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign prime_valid = prime_valid_q;
  assign prime_value = prime_value_q;
  assign prime_count = prime_count_q;
`ifdef PRIME_SCAN_BITMAP_EN
  assign bitmap      = bitmap_q;
`else
  assign bitmap      = 16'h0000;
`endif

endmodule

// File: doc/prime_scan_ctrl.md
# prime_scan_ctrl

Sequential sweep controller placed directly upstream of the 4-bit prime detector. On a start request it steps the detector's 4-bit `N` input through a programmed range, samples the detector's `F` flag for each value, streams every prime found, and accumulates a prime count and an optional 16-bit result bitmap. It is used to exercise the combinational detector on the board, replacing manual stimulus.

## Interface
- `HOLD_CYCLES`, default 1: cycles each `N` value is held before `F` is sampled. Legal range 1..15.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `start` in 1: scan request; accepted only in IDLE.
- `lo` in 4: first value of the range; captured at acceptance.
- `hi` in 4: last value of the range, inclusive; captured at acceptance.
- `N` out 4: value driven to the detector.
- `F` in 1: prime flag returned by the detector for the current `N`.
- `busy` out 1: high from the cycle after acceptance until DONE.
- `done` out 1: one-cycle pulse at the end of a scan.
- `err` out 1: high together with `done` when the captured range had `lo > hi`.
- `prime_valid` out 1: one-cycle pulse for each prime found.
- `prime_value` out 4: the prime reported with `prime_valid`.
- `prime_count` out 5: number of primes found in the last scan (0..16).
- `bitmap` out 16: bit k is set when k was scanned and found prime.

## Operation
- States:
  - IDLE → SCAN on `start` when `lo <= hi`.
  - IDLE → DONE on `start` when `lo > hi`.
  - SCAN → SCAN when the hold window ends and `N != hi`.
  - SCAN → DONE when the hold window ends and `N == hi`.
  - DONE → IDLE unconditionally.
- Acceptance clears `prime_count`, `bitmap` and `err`, loads `N <= lo`, and resets the hold counter.
- Hold window: a 4-bit counter runs 0..HOLD_CYCLES-1. `F` is sampled on the edge where the counter equals HOLD_CYCLES-1.
- On a sampling edge with `F=1`:
  - `prime_count` increments.
  - `bitmap[N]` is set.
  - `prime_valid` is 1 and `prime_value` equals `N` for the next cycle.
- On a sampling edge with `F=0`: `prime_valid` is 0 for the next cycle.
- On every sampling edge, `N` increments unless `N == hi`. The hi comparison is made before the increment, so `hi = 15` never wraps to 0.
- `prime_count` is 5 bits, so a full 16-value range cannot overflow.
- `start` while busy, or while in DONE, is ignored. No queuing.
- Results (`prime_count`, `bitmap`, `prime_value`, `err`) hold their values in IDLE until the next accepted start.
- `rst` mid-scan returns the block to IDLE on that edge with every output at its reset value. No `done` pulse is issued.

## Timing
- Reset values: `N=0`, `busy=0`, `done=0`, `err=0`, `prime_valid=0`, `prime_value=0`, `prime_count=0`, `bitmap=16'h0000`.
- `start` is sampled at edge E0. `N=lo` and `busy=1` are visible from cycle 1.
- Scan length is (hi-lo+1)*HOLD_CYCLES cycles.
- `done` is high in the cycle after the final sample edge, with `busy=0` in that same cycle.
- `prime_valid` for the last value coincides with `done`.
- Error path: `done=1` and `err=1` in cycle 1; `busy` stays 0.
- The earliest new start is accepted in the cycle after `done`.
- `F` is treated as combinational from `N`, so it must settle within HOLD_CYCLES clocks.

## Configuration
- `PRIME_SCAN_BITMAP_EN`, when defined: the `bitmap` register and its update logic are built as described above.
- When undefined: no bitmap storage is generated and `bitmap` is tied to 16'h0000.
- Count, streaming and handshake behaviour are identical with or without the macro.

## Test plan
- Full range, HOLD_CYCLES=1, `lo=0`, `hi=15`:
  - `done` arrives 17 cycles after the start edge with `prime_count=6` and `bitmap=16'h28AC`.
  - `prime_valid` pulses carry 2, 3, 5, 7, 11, 13 in that order.
- Single value, `lo=hi=13`: `prime_count=1`, `bitmap=16'h2000`, `N` stays 13, `done` in cycle 2.
- Inverted range, `lo=9`, `hi=4`: `done=1` and `err=1` in cycle 1, `prime_count=0`, `busy` never asserts.
- HOLD_CYCLES=3, `lo=14`, `hi=15`:
  - each `N` is held 3 cycles, `done` arrives in cycle 7, `prime_count=0`.
  - `N` ends at 15 with no wrap.
- `start` pulsed again mid-scan: ignored, and the first scan's results are unchanged.
- `rst` asserted mid-scan at `N=6`:
  - next cycle shows every output at its reset value, with no `done`.
  - a following scan with `lo=0`, `hi=7` gives `prime_count=4` and `bitmap=16'h00AC`, or 16'h0000 with `PRIME_SCAN_BITMAP_EN` undefined.
